// File: rtl/video_mode_sequencer.sv
// Measures vsync period and lines per field, classifies the video format, and hands a
// format that has stayed stable for STABLE_COUNT fields to downstream logic via req/ack.
module video_mode_sequencer #(
   parameter int unsigned CLK_HZ         = 50000000,
   parameter int unsigned STABLE_COUNT   = 3,
   parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 20
) (
   input  logic        clk_50mhz_in,
   input  logic        rst_in,
   input  logic        vsync_in,
   input  logic        hsync_in,
   input  logic        cfg_ack_in,
   output logic        cfg_req_out,
   output logic [7:0]  cfg_format_out,
   output logic        format_valid_out,
   output logic [10:0] lines_out,
   output logic [1:0]  state_dbg_out
);

   localparam int unsigned SW       = $clog2(STABLE_COUNT + 1);
   localparam logic [SW-1:0] STABLE_SW = SW'(STABLE_COUNT);
   localparam logic [SW-1:0] ONE_SW    = SW'(1);
   localparam logic [31:0] P50_MIN  = 32'(CLK_HZ / 53);
   localparam logic [31:0] P50_MAX  = 32'(CLK_HZ / 47);
   localparam logic [31:0] P60_MIN  = 32'(CLK_HZ / 63);
   localparam logic [31:0] P60_MAX  = 32'(CLK_HZ / 57);
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, LOCKED = 2'd2} state_t;

   // Sync pipes: bit 0 first stage, bit 1 synchronized, bit 2 previous synchronized value.
   logic [2:0]    vs_pipe_q, vs_pipe_d, hs_pipe_q, hs_pipe_d;
   logic [31:0]   period_q, period_d, tmo_q, tmo_d;
   logic [10:0]   line_q, line_d, lines_q, lines_d;
   logic [7:0]    prev_cand_q, prev_cand_d;
   logic [SW-1:0] stable_q, stable_d;
   logic          partial_q, partial_d;
   logic          vs_pulse, hs_pulse, is50, is60;
   logic [7:0]    cand;

   state_t        state_q;
   logic          cfg_req_q, valid_q;
   logic [7:0]    fmt_q;

   always_comb begin
      vs_pipe_d = {vs_pipe_q[1:0], vsync_in};
      hs_pipe_d = {hs_pipe_q[1:0], hsync_in};
      vs_pulse  = vs_pipe_q[2] & ~vs_pipe_q[1];
      hs_pulse  = hs_pipe_q[2] & ~hs_pipe_q[1];

      is50 = (period_q >= P50_MIN) && (period_q <= P50_MAX);
      is60 = (period_q >= P60_MIN) && (period_q <= P60_MAX);
      cand = 8'h00;
      if (is50 && line_q >= 11'd300 && line_q <= 11'd330) cand = 8'h01;
      if (is50 && line_q >= 11'd600 && line_q <= 11'd650) cand = 8'h03;
      if (is60 && line_q >= 11'd250 && line_q <= 11'd275) cand = 8'h02;
      if (is60 && line_q >= 11'd510 && line_q <= 11'd540) cand = 8'h04;

      period_d    = (&period_q) ? period_q : period_q + 32'd1;
      line_d      = (hs_pulse && line_q != 11'h7FF) ? line_q + 11'd1 : line_q;
      tmo_d       = tmo_q + 32'd1;
      lines_d     = lines_q;
      prev_cand_d = prev_cand_q;
      stable_d    = stable_q;
      partial_d   = partial_q;

      if (vs_pulse) begin
         // An hsync edge landing with vsync belongs to the field that is starting.
         period_d  = 32'd1;
         line_d    = {10'd0, hs_pulse};
         tmo_d     = 32'd0;
         partial_d = 1'b0;
         if (!partial_q) begin
            lines_d = line_q;
            if (cand == prev_cand_q) begin
               if (stable_q != STABLE_SW) stable_d = stable_q + ONE_SW;
            end else begin
               stable_d    = ONE_SW;
               prev_cand_d = cand;
            end
         end
      end else if (tmo_q == TMO_LAST) begin
         tmo_d       = 32'd0;
         prev_cand_d = 8'h00;
         stable_d    = STABLE_SW;
         lines_d     = 11'd0;
         partial_d   = 1'b1;
      end
   end

   always_ff @(posedge clk_50mhz_in) begin
      if (rst_in) begin
         vs_pipe_q   <= 3'b000;
         hs_pipe_q   <= 3'b000;
         period_q    <= 32'd0;
         line_q      <= 11'd0;
         tmo_q       <= 32'd0;
         lines_q     <= 11'd0;
         prev_cand_q <= 8'h00;
         stable_q    <= '0;
         partial_q   <= 1'b1;
      end else begin
         vs_pipe_q   <= vs_pipe_d;
         hs_pipe_q   <= hs_pipe_d;
         period_q    <= period_d;
         line_q      <= line_d;
         tmo_q       <= tmo_d;
         lines_q     <= lines_d;
         prev_cand_q <= prev_cand_d;
         stable_q    <= stable_d;
         partial_q   <= partial_d;
      end
   end

   // Handshake: cfg_req_out rises together with a new cfg_format_out; both hold until
   // cfg_ack_in is sampled high, and cfg_req_out drops on the following edge.
   always_ff @(posedge clk_50mhz_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         cfg_req_q <= 1'b0;
         fmt_q     <= 8'h00;
         valid_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, LOCKED: begin
               if (stable_q == STABLE_SW && prev_cand_q != fmt_q) begin
                  state_q   <= REQ;
                  fmt_q     <= prev_cand_q;
                  cfg_req_q <= 1'b1;
                  valid_q   <= 1'b0;
               end
            end
            REQ: begin
               if (cfg_ack_in) begin
                  cfg_req_q <= 1'b0;
                  if (fmt_q != 8'h00) begin
                     state_q <= LOCKED;
                     valid_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cfg_req_out      = cfg_req_q;
   assign cfg_format_out   = fmt_q;
   assign format_valid_out = valid_q;
   assign lines_out        = lines_q;
   assign state_dbg_out    = state_q;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Directed sequence of randomized video fields against a rule-level model of the
// format classifier and commit handshake.
module tb_video_mode_sequencer;

   localparam int CLK_HZ = 60000;
   localparam int STABLE = 3;
   localparam int TMO    = 3000;

   logic        clk = 1'b0;
   logic        rst_in = 1'b1;
   logic        vsync_in = 1'b1;
   logic        hsync_in = 1'b1;
   logic        cfg_ack_in = 1'b0;
   logic        cfg_req_out;
   logic [7:0]  cfg_format_out;
   logic        format_valid_out;
   logic [10:0] lines_out;
   logic [1:0]  state_dbg_out;

   video_mode_sequencer #(
      .CLK_HZ(CLK_HZ), .STABLE_COUNT(STABLE), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_50mhz_in(clk), .rst_in(rst_in), .vsync_in(vsync_in), .hsync_in(hsync_in),
      .cfg_ack_in(cfg_ack_in), .cfg_req_out(cfg_req_out), .cfg_format_out(cfg_format_out),
      .format_valid_out(format_valid_out), .lines_out(lines_out), .state_dbg_out(state_dbg_out)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state
   int n_pass = 0, n_fail = 0, n_total = 0;
   logic [7:0]  exp_q[$];      // classifications since last reset/timeout
   logic [7:0]  m_fmt = 8'h00;
   bit          m_req = 1'b0, m_valid = 1'b0, m_partial = 1'b1;
   logic [10:0] m_lines = 11'd0;
   int          last_p = 0, last_l = 0, edge_cyc = 0;

   int kp[6] = '{951, 1053, 1131, 1277, 1000, 1000};
   int kl[6] = '{262, 262, 312, 312, 249, 276};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, " req"},   32'(cfg_req_out),      32'(m_req));
      chk({tag, " fmt"},   32'(cfg_format_out),   32'(m_fmt));
      chk({tag, " valid"}, 32'(format_valid_out), 32'(m_valid));
      chk({tag, " lines"}, 32'(lines_out),        32'(m_lines));
   endtask

   // reference model
   function automatic logic [7:0] classify(input int p, input int l);
      bit r50, r60;
      r50 = (p >= CLK_HZ / 53) && (p <= CLK_HZ / 47);
      r60 = (p >= CLK_HZ / 63) && (p <= CLK_HZ / 57);
      if (r50 && l >= 300 && l <= 330) return 8'h01;
      if (r50 && l >= 600 && l <= 650) return 8'h03;
      if (r60 && l >= 250 && l <= 275) return 8'h02;
      if (r60 && l >= 510 && l <= 540) return 8'h04;
      return 8'h00;
   endfunction

   function automatic bit stable_code(output logic [7:0] c);
      int n;
      n = exp_q.size();
      c = 8'h00;
      if (n < STABLE) return 1'b0;
      for (int i = 2; i <= STABLE; i++)
         if (exp_q[n-i] !== exp_q[n-1]) return 1'b0;
      c = exp_q[n-1];
      return 1'b1;
   endfunction

   task automatic model_try_request();
      logic [7:0] c;
      bit s;
      s = stable_code(c);
      if (!m_req && s && c !== m_fmt) begin
         m_req = 1'b1; m_fmt = c; m_valid = 1'b0;
      end
   endtask

   task automatic model_vsync();
      if (m_partial) m_partial = 1'b0;
      else begin
         exp_q.push_back(classify(last_p, last_l));
         m_lines = 11'(last_l);
      end
      model_try_request();
   endtask

   task automatic model_ack();
      if (m_req) begin
         m_req = 1'b0;
         m_valid = (m_fmt != 8'h00);
      end
   endtask

   task automatic model_timeout();
      exp_q.delete();
      for (int i = 0; i < STABLE; i++) exp_q.push_back(8'h00);
      m_lines = 11'd0;
      m_partial = 1'b1;
      model_try_request();
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_fmt = 8'h00; m_req = 1'b0; m_valid = 1'b0; m_lines = 11'd0; m_partial = 1'b1;
   endtask

   // driver tasks
   task automatic pick(input int code, output int p, output int l);
      int plo, phi, llo, lhi, sel;
      plo = CLK_HZ / 63; phi = CLK_HZ / 57; llo = 250; lhi = 275;
      case (code)
         1: begin plo = CLK_HZ / 53; phi = CLK_HZ / 47; llo = 300; lhi = 330; end
         3: begin plo = CLK_HZ / 53; phi = CLK_HZ / 47; llo = 600; lhi = 636; end
         4: begin llo = 510; lhi = 525; end
         default: ;
      endcase
      sel = int'($urandom_range(0, 3));
      l = (sel == 0) ? llo : (sel == 1) ? lhi : int'($urandom_range(lhi, llo));
      if (2 * l + 2 > plo) plo = 2 * l + 2;
      sel = int'($urandom_range(0, 3));
      p = (sel == 0) ? plo : (sel == 1) ? phi : int'($urandom_range(phi, plo));
   endtask

   // One field: vsync low for 4 clocks from offset 0, l hsync falling edges at 2-clock
   // spacing (phase 0 puts the first one on the vsync edge).
   task automatic run_field(input int p, input int l, input int ack_off, input int rst_off);
      int ph;
      ph = int'($urandom_range(1, 0));
      for (int c = 0; c < p; c++) begin
         @(negedge clk);
         if (c == 6) begin model_vsync(); check_outputs("field"); end
         if (ack_off >= 0 && c == ack_off + 1) begin model_ack(); check_outputs("post_ack"); end
         if (ack_off >= 0 && c == ack_off + 4) begin model_try_request(); check_outputs("after_ack"); end
         if (rst_off >= 0 && c == rst_off + 1) begin model_reset(); check_outputs("mid_reset"); end
         if (c == 0) edge_cyc = cyc;
         vsync_in   = (c >= 4);
         hsync_in   = !((c % 2 == ph) && (c / 2 < l));
         cfg_ack_in = (c == ack_off);
         rst_in     = (c == rst_off);
      end
      last_p = p;
      last_l = l;
   endtask

   task automatic wait_timeout();
      int delta;
      bit seen;
      delta = -1;
      seen = 1'b0;
      vsync_in = 1'b1;
      hsync_in = 1'b1;
      for (int i = 0; i < 2 * TMO && !seen; i++) begin
         @(negedge clk);
         if (cfg_req_out === 1'b1) begin
            seen = 1'b1;
            delta = cyc - edge_cyc;
         end
      end
      chk("timeout_latency", 32'(delta >= TMO && delta <= TMO + 8), 32'd1);
      model_timeout();
      check_outputs("timeout");
   endtask

   task automatic ack_idle();
      @(negedge clk);
      cfg_ack_in = 1'b1;
      @(negedge clk);
      cfg_ack_in = 1'b0;
      model_ack();
      check_outputs("idle_ack");
      repeat (3) @(negedge clk);
      model_try_request();
      check_outputs("idle_after_ack");
   endtask

   initial begin
      int p, l;
      // reset
      rst_in = 1'b1;
      repeat (3) @(negedge clk);
      model_reset();
      check_outputs("reset");
      rst_in = 1'b0;

      // 480i60 lock-in, ack, then an ack outside REQ
      for (int i = 0; i < 4; i++) begin
         pick(2, p, l);
         run_field(p, l, (i == 3) ? 20 : -1, -1);
      end
      pick(2, p, l);
      run_field(p, l, 30, -1);

      // switch to 576i50, leave the request unacknowledged
      for (int i = 0; i < 4; i++) begin
         pick(1, p, l);
         run_field(p, l, -1, -1);
      end

      // fields change to 480p60 while the request is held; late ack, then a new request
      for (int i = 0; i < 6; i++) begin
         pick(4, p, l);
         run_field(p, l, (i >= 4) ? 20 : -1, -1);
      end

      // vsync stops: loss of signal
      wait_timeout();
      ack_idle();

      // alternating 262/525 lines at 60 Hz never stabilises
      for (int i = 0; i < 8; i++) begin
         l = (i % 2 == 1) ? 525 : 262;
         p = (i % 2 == 1) ? 1052 : int'($urandom_range(1052, 952));
         run_field(p, l, -1, -1);
      end

      // just outside each rate/line window
      for (int k = 0; k < 6; k++)
         for (int j = 0; j < 3; j++) run_field(kp[k], kl[k], -1, -1);
      run_field(1000, 100, -1, -1);

      // reset while requesting, then 576p50 from a partial first field
      for (int i = 0; i < 4; i++) begin
         pick(2, p, l);
         run_field(p, l, -1, (i == 3) ? 100 : -1);
      end
      for (int i = 0; i < 5; i++) begin
         pick(3, p, l);
         run_field(p, l, (i == 3) ? 20 : -1, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/video_mode_sequencer.md
VIDEO_MODE_SEQUENCER -- requirements
Module: video_mode_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning the clk_50mhz_in frequency in Hz from which every period window is derived.
REQ-002 The block SHALL have parameter STABLE_COUNT, default 3, meaning the number of consecutive identical field classifications required before a commit.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default CLK_HZ/20, meaning the number of clocks without a vsync falling edge that declares loss of signal.
REQ-004 clk_50mhz_in  input  1  sole clock; every register is clocked on its rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-high.
REQ-006 vsync_in  input  1  asynchronous; its falling edge marks the start of a field.
REQ-007 hsync_in  input  1  asynchronous; each falling edge marks one line.
REQ-008 cfg_ack_in  input  1  downstream acknowledge of cfg_req_out.
REQ-009 cfg_req_out  output  1  configuration request; held high until acknowledged.
REQ-010 cfg_format_out  output  8  committed format code: 0x00 none, 0x01 576i50, 0x02 480i60, 0x03 576p50, 0x04 480p60.
REQ-011 format_valid_out  output  1  high while an acknowledged commit carries a nonzero code.
REQ-012 lines_out  output  11  line count of the last complete field.

Function
REQ-013 vsync_in and hsync_in SHALL each pass through a 2-flop synchronizer followed by a falling-edge detector producing a 1-clock pulse.
REQ-014 Period counter (32 bit) SHALL increment every clock and saturate at all-ones; line counter (11 bit) SHALL increment on each hsync pulse and saturate at 2047.
REQ-015 The first vsync pulse after reset or after a timeout is partial: the block SHALL restart both counters and SHALL NOT classify.
REQ-016 Each later vsync pulse SHALL, in the same cycle: latch the line count into lines_out, form a candidate code, reload the period counter to 1, and reload the line counter to 0.
REQ-017 An hsync pulse coincident with a vsync pulse SHALL count into the new field, i.e. the line counter loads 1 instead of 0.
REQ-018 Rate is 50 Hz if CLK_HZ/53 <= period <= CLK_HZ/47, and 60 Hz if CLK_HZ/63 <= period <= CLK_HZ/57 (integer division, inclusive bounds).
REQ-019 Candidate SHALL be: 0x01 for 50 Hz with lines 300..330; 0x03 for 50 Hz with 600..650; 0x02 for 60 Hz with 250..275; 0x04 for 60 Hz with 510..540; 0x00 for anything else.
REQ-020 If candidate equals the previous candidate, stable_cnt SHALL increment, saturating at STABLE_COUNT; otherwise stable_cnt SHALL load 1 and the previous candidate SHALL update.
REQ-021 FSM states SHALL be IDLE, REQ and LOCKED.
REQ-022 From IDLE or LOCKED, when stable_cnt == STABLE_COUNT and the stable candidate != cfg_format_out, the FSM SHALL go to REQ.
REQ-023 On entry to REQ, cfg_format_out SHALL load the candidate, cfg_req_out SHALL rise, and format_valid_out SHALL clear, all in the same cycle.
REQ-024 In REQ, cfg_req_out and cfg_format_out SHALL stay constant until cfg_ack_in is sampled high.
REQ-025 On the cycle cfg_ack_in is sampled high, the FSM SHALL go to LOCKED if the code is nonzero (format_valid_out=1 next cycle), else to IDLE; cfg_req_out SHALL fall the same next cycle.
REQ-026 cfg_ack_in SHALL be ignored outside REQ.
REQ-027 Classification SHALL continue during REQ; a differing stable candidate SHALL raise a new request no earlier than the cycle after cfg_req_out falls.
REQ-028 cfg_req_out SHALL rise at most 5 clocks after the vsync_in pin edge that completes stability.
REQ-029 If TIMEOUT_CYCLES elapse without a vsync pulse, the block SHALL force candidate 0x00 with stable_cnt = STABLE_COUNT, clear lines_out, and treat the next vsync as partial.
REQ-030 The timeout counter SHALL restart on every vsync pulse and after each timeout.

Reset
REQ-031 While rst_in is high at a clock edge, every output (cfg_req_out, cfg_format_out, format_valid_out, lines_out), every counter, stable_cnt and the previous candidate SHALL go to 0, the FSM SHALL go to IDLE, and the partial-field flag SHALL set.
REQ-032 Reset asserted during REQ SHALL drop cfg_req_out on the next edge without waiting for cfg_ack_in.

Verification (CLK_HZ=60000, TIMEOUT_CYCLES=3000)
REQ-033 60 Hz fields (period 1000 clk) with 262 lines, 4 vsync edges -> cfg_req_out=1, cfg_format_out=0x02; ack -> format_valid_out=1, lines_out=262.
REQ-034 Locked 0x02, then switch to period 1200 with 312 lines -> after 3 fields: request 0x01, format_valid_out=0 until ack.
REQ-035 Classifications alternating 262/525 lines at 60 Hz -> no request ever; stable_cnt never reaches 3.
REQ-036 Locked 0x04, vsync stopped -> 3000 clk later: request 0x00, lines_out=0; ack -> IDLE, format_valid_out=0.
REQ-037 cfg_ack_in held low for 500 clk while fields change to 480p60 -> cfg_format_out unchanged during REQ; after ack, request 0x04 on a later cycle.
REQ-038 rst_in pulsed for 1 clk while in REQ -> all outputs 0 next edge; first field after reset not classified.
